// File: rtl/orth_dds_if.sv
// Sample-enable, tuning and quadrature output bundle for orth_dds.
interface orth_dds_if #(
    parameter int unsigned PW = 32,
    parameter int unsigned DW = 24
);
    logic                 en;
    logic [PW-1:0]        freq;
    logic [PW-1:0]        phase;
    logic signed [DW-1:0] sin;
    logic signed [DW-1:0] cos;

    modport master (output en, output freq, output phase, input sin, input cos);
    modport slave  (input en, input freq, input phase, output sin, output cos);
endinterface

// File: rtl/orth_dds.sv
// Orthogonal DDS: one phase accumulator feeding a constant sine ROM for sin/cos samples.
// Define ORTH_DDS_QUARTER_LUT_EN to keep only the first quadrant of the table.
module orth_dds #(
    parameter int unsigned PW = 32,
    parameter int unsigned DW = 24,
    parameter int unsigned AW = 13
) (
    input logic       clk,
    input logic       rst,
    orth_dds_if.slave bus
);
    localparam int unsigned LW    = PW - AW;
    localparam int unsigned HALF  = 2 ** (AW - 1);
    localparam int unsigned QUART = 2 ** (AW - 2);
    localparam real         PI    = 3.14159265358979323846;
    localparam real         AMP   = (2.0 ** (DW - 1)) - 1.0;

    // Taylor series; the argument never exceeds pi/2, so 14 terms reach double precision.
    function automatic real sin_poly(real x);
        real term;
        real sum;
        term = x;
        sum  = x;
        for (int n = 1; n < 14; n++) begin
            term = -term * x * x / real'((2 * n) * (2 * n + 1));
            sum  = sum + term;
        end
        return sum;
    endfunction

    // First-quadrant entry, rounded half away from zero (value is never negative here).
    function automatic logic signed [DW-1:0] quad_val(int unsigned m);
        real v;
        v = AMP * sin_poly(PI * real'(m) / real'(HALF));
        if (v > AMP) v = AMP;
        return DW'($rtoi(v + 0.5));
    endfunction

    logic [PW-1:0]        acc_q;
    logic signed [DW-1:0] sin_q;
    logic signed [DW-1:0] cos_q;
    logic                 carry;
    logic [AW-1:0]        idx [2];
    logic signed [DW-1:0] val [2];

    // Only the top AW bits of acc+phase are needed; the low half contributes just its carry.
    assign carry  = acc_q[LW-1:0] > ~bus.phase[LW-1:0];
    assign idx[0] = acc_q[PW-1 -: AW] + bus.phase[PW-1 -: AW] + AW'(carry);
    assign idx[1] = idx[0] + AW'(QUART);

`ifdef ORTH_DDS_QUARTER_LUT_EN
    localparam int unsigned QN = QUART + 1;

    logic signed [DW-1:0] rom [QN];

    for (genvar k = 0; k < QN; k++) begin : g_rom
        localparam logic signed [DW-1:0] Entry = quad_val(k);
        assign rom[k] = Entry;
    end

    // Quadrants 2/4 mirror the address, quadrants 3/4 negate the value.
    for (genvar c = 0; c < 2; c++) begin : g_ch
        logic [AW-3:0] low;
        logic [AW-2:0] addr;
        assign low    = idx[c][AW-3:0];
        assign addr   = idx[c][AW-2] ? (AW-1)'(QUART) - {1'b0, low} : {1'b0, low};
        assign val[c] = idx[c][AW-1] ? -rom[addr] : rom[addr];
    end
`else
    localparam int unsigned FN = 2 ** AW;

    // Built by folding onto the first quadrant so the table is exactly odd-symmetric.
    function automatic logic signed [DW-1:0] full_val(int unsigned k);
        int unsigned          q;
        logic signed [DW-1:0] v;
        q = k % HALF;
        v = quad_val((q <= QUART) ? q : HALF - q);
        return (k >= HALF) ? -v : v;
    endfunction

    logic signed [DW-1:0] rom [FN];

    for (genvar k = 0; k < FN; k++) begin : g_rom
        localparam logic signed [DW-1:0] Entry = full_val(k);
        assign rom[k] = Entry;
    end

    for (genvar c = 0; c < 2; c++) begin : g_ch
        assign val[c] = rom[idx[c]];
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
            sin_q <= '0;
            cos_q <= '0;
        end else if (bus.en) begin
            acc_q <= acc_q + bus.freq;
            sin_q <= val[0];
            cos_q <= val[1];
        end
    end

    assign bus.sin = sin_q;
    assign bus.cos = cos_q;
endmodule

// File: tb/tb_orth_dds.sv
// Self-checking bench for orth_dds: expected samples are queued when driven, popped one clock later.
module tb_orth_dds;
    localparam int A = 8388607;

    logic clk = 1'b0;
    logic rst;

    orth_dds_if #(.PW(32), .DW(24)) bus ();

    orth_dds #(.PW(32), .DW(24), .AW(13)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        int s;
        int c;
    } exp_t;

    exp_t        sb[$];
    int          checks   = 0;
    int          failures = 0;
    logic [31:0] macc     = '0;
    int          ms       = 0;
    int          mc       = 0;

    function automatic int model_s(int k);
        real v;
        v = 8388607.0 * $sin(2.0 * 3.14159265358979323846 * real'(k) / 8192.0);
        if (v >= 0.0) return int'($floor(v + 0.5));
        return -int'($floor(-v + 0.5));
    endfunction

    // Drive one cycle, push the model's expectation, and land #1 after the edge.
    task automatic drive(input logic r, input logic e, input logic [31:0] f,
                         input logic [31:0] ph);
        logic [31:0] p;
        int          idx;
        rst       = r;
        bus.en    = e;
        bus.freq  = f;
        bus.phase = ph;
        if (r) begin
            macc = '0;
            ms   = 0;
            mc   = 0;
        end else if (e) begin
            p    = macc + ph;
            idx  = int'(p[31:19]);
            ms   = model_s(idx);
            mc   = model_s((idx + 2048) % 8192);
            macc = macc + f;
        end
        sb.push_back('{ms, mc});
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        exp_t x;
        for (int i = 0; i < 8; i++) begin
            if (i < 5) drive(1'b1, 1'b1, $urandom, $urandom);
            else       drive(1'b0, 1'b0, $urandom, $urandom);
            x = sb.pop_front();
            checks++;
            if (int'(bus.sin) !== x.s || int'(bus.cos) !== x.c) begin
                failures++;
                $display("FAIL reset[%0d]: sin=%0d cos=%0d expected sin=%0d cos=%0d",
                         i, bus.sin, bus.cos, x.s, x.c);
            end
        end
    endtask

    // Accumulator must still be 0 here, left over from the reset test.
    task automatic test_quarter_step();
        exp_t x;
        int   qs[4];
        int   qc[4];
        qs = '{0, A, 0, -A};
        qc = '{A, 0, -A, 0};
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 1'b1, 32'h4000_0000, 32'h0);
            x = sb.pop_front();
            checks++;
            if (int'(bus.sin) !== x.s || int'(bus.cos) !== x.c) begin
                failures++;
                $display("FAIL quarter_model[%0d]: sin=%0d cos=%0d expected sin=%0d cos=%0d",
                         i, bus.sin, bus.cos, x.s, x.c);
            end
            checks++;
            if (int'(bus.sin) !== qs[i % 4] || int'(bus.cos) !== qc[i % 4]) begin
                failures++;
                $display("FAIL quarter_const[%0d]: sin=%0d cos=%0d expected sin=%0d cos=%0d",
                         i, bus.sin, bus.cos, qs[i % 4], qc[i % 4]);
            end
        end
    endtask

    task automatic test_gapped_fs5();
        exp_t    x;
        int      hs[$];
        int      hc[$];
        longint  pw;
        logic    e;
        int      n;
        drive(1'b1, 1'b0, 32'h0, 32'h0);
        void'(sb.pop_front());
        for (int i = 0; i < 60; i++) begin
            e = 1'($urandom_range(0, 1));
            drive(1'b0, e, 32'd858993459, 32'h0);
            x = sb.pop_front();
            checks++;
            if (int'(bus.sin) !== x.s || int'(bus.cos) !== x.c) begin
                failures++;
                $display("FAIL fs5[%0d]: sin=%0d cos=%0d expected sin=%0d cos=%0d",
                         i, bus.sin, bus.cos, x.s, x.c);
            end
            if (e) begin
                hs.push_back(int'(bus.sin));
                hc.push_back(int'(bus.cos));
                pw = longint'(bus.sin) * longint'(bus.sin) + longint'(bus.cos) * longint'(bus.cos);
                checks++;
                if (pw > longint'(A) * A + 2 * A || pw < longint'(A) * A - 2 * A) begin
                    failures++;
                    $display("FAIL fs5_power[%0d]: sum_sq=%0d expected within %0d +/- %0d",
                             i, pw, longint'(A) * A, 2 * A);
                end
                n = hs.size() - 1;
                // Five steps move acc by -1 LSB, so the period holds from the second sample on.
                if (n >= 6) begin
                    checks++;
                    if (hs[n] !== hs[n - 5] || hc[n] !== hc[n - 5]) begin
                        failures++;
                        $display("FAIL fs5_period[%0d]: sin=%0d cos=%0d expected sin=%0d cos=%0d",
                                 n, hs[n], hc[n], hs[n - 5], hc[n - 5]);
                    end
                end
            end
        end
    endtask

    task automatic test_phase_offset();
        exp_t        x;
        logic [31:0] ph;
        int          es;
        int          ec;
        drive(1'b1, 1'b0, 32'h0, 32'h0);
        void'(sb.pop_front());
        for (int i = 0; i < 8; i++) begin
            ph = (i < 4) ? 32'h4000_0000 : 32'h8000_0000;
            es = (i < 4) ? A : 0;
            ec = (i < 4) ? 0 : -A;
            drive(1'b0, 1'b1, 32'h0, ph);
            x = sb.pop_front();
            checks++;
            if (int'(bus.sin) !== x.s || int'(bus.cos) !== x.c) begin
                failures++;
                $display("FAIL phase_model[%0d]: sin=%0d cos=%0d expected sin=%0d cos=%0d",
                         i, bus.sin, bus.cos, x.s, x.c);
            end
            checks++;
            if (int'(bus.sin) !== es || int'(bus.cos) !== ec) begin
                failures++;
                $display("FAIL phase_const[%0d]: sin=%0d cos=%0d expected sin=%0d cos=%0d",
                         i, bus.sin, bus.cos, es, ec);
            end
        end
    endtask

    task automatic test_wrap_reset();
        exp_t x;
        drive(1'b1, 1'b0, 32'h0, 32'h0);
        void'(sb.pop_front());
        for (int i = 0; i < 9; i++) begin
            if (i < 6)       drive(1'b0, 1'b1, 32'hFFFF_FFFF, 32'h0);
            else if (i == 6) drive(1'b1, 1'b1, 32'hFFFF_FFFF, 32'h0);
            else if (i == 7) drive(1'b0, 1'b0, 32'h1234_5678, 32'h0);
            else             drive(1'b0, 1'b1, 32'h1234_5678, 32'h0);
            x = sb.pop_front();
            checks++;
            if (int'(bus.sin) !== x.s || int'(bus.cos) !== x.c) begin
                failures++;
                $display("FAIL wrap[%0d]: sin=%0d cos=%0d expected sin=%0d cos=%0d",
                         i, bus.sin, bus.cos, x.s, x.c);
            end
        end
        checks++;
        if (int'(bus.sin) !== 0 || int'(bus.cos) !== A) begin
            failures++;
            $display("FAIL restart: sin=%0d cos=%0d expected sin=0 cos=%0d",
                     bus.sin, bus.cos, A);
        end
    endtask

    task automatic test_back_to_back();
        exp_t x;
        for (int i = 0; i < 40; i++) begin
            drive(1'b0, 1'($urandom_range(0, 3) != 0), $urandom, $urandom);
            x = sb.pop_front();
            checks++;
            if (int'(bus.sin) !== x.s || int'(bus.cos) !== x.c) begin
                failures++;
                $display("FAIL b2b[%0d]: sin=%0d cos=%0d expected sin=%0d cos=%0d",
                         i, bus.sin, bus.cos, x.s, x.c);
            end
        end
    endtask

    initial begin
        rst       = 1'b1;
        bus.en    = 1'b0;
        bus.freq  = '0;
        bus.phase = '0;
        @(posedge clk);
        #1;
        test_reset();
        test_quarter_step();
        test_gapped_fs5();
        test_phase_offset();
        test_wrap_reset();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
